// File: rtl/line_fill_ctrl.sv
// Cache line refill controller: issues one 4-beat burst read per miss and writes the assembled line.
// Optional critical-word forwarding is built when LINE_FILL_CRIT_WORD_EN is defined.
module line_fill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_W-1:0]     req_addr,
   output logic                  req_ready,
   output logic                  mem_ar_valid,
   input  logic                  mem_ar_ready,
   output logic [ADDR_W-1:0]     mem_ar_addr,
   input  logic                  mem_r_valid,
   input  logic [DATA_W-1:0]     mem_r_data,
   input  logic                  mem_r_last,
   output logic                  mem_r_ready,
   output logic                  line_we,
   output logic [ADDR_W-1:0]     line_addr,
   output logic [4*DATA_W-1:0]   line_data,
   output logic                  crit_valid,
   output logic [DATA_W-1:0]     crit_data,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_r;
   logic [1:0]          cnt;
   logic [4*DATA_W-1:0] line_r;
   logic                err_r;
   logic                accept;
   logic                beat;
   logic                carry;
   logic                unused_bits;

   assign accept      = (state == IDLE) && req_valid;
   assign beat        = (state == DATA) && mem_r_valid;
   assign carry       = (cnt == 2'd3);
   assign unused_bits = ^req_addr[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      mem_ar_valid = 1'b0;
      mem_r_ready  = 1'b0;
      line_we      = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = ADDR;
         end
         ADDR: begin
            mem_ar_valid = 1'b1;
            if (mem_ar_ready) state_nxt = DATA;
         end
         DATA: begin
            mem_r_ready = 1'b1;
            if (mem_r_valid && carry) state_nxt = WRITE;
         end
         WRITE: begin
            line_we   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Beat capture: err flags a last marker on the wrong beat, but the fill always takes four beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r <= '0;
         cnt    <= 2'd0;
         line_r <= '0;
         err_r  <= 1'b0;
      end else begin
         if (accept) begin
            addr_r <= {req_addr[ADDR_W-1:4], 4'b0000};
            cnt    <= 2'd0;
            err_r  <= 1'b0;
         end
         if (beat) begin
            for (int k = 0; k < 4; k++) begin
               if (cnt == 2'(k)) line_r[k*DATA_W +: DATA_W] <= mem_r_data;
            end
            cnt <= cnt + 2'd1;
            if (carry != mem_r_last) err_r <= 1'b1;
         end
      end
   end

   assign mem_ar_addr = addr_r;
   assign line_addr   = addr_r;
   assign line_data   = line_r;
   assign err         = err_r;

`ifdef LINE_FILL_CRIT_WORD_EN
   logic [1:0]        word_r;
   logic              crit_v_r;
   logic [DATA_W-1:0] crit_d_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_r   <= 2'd0;
         crit_v_r <= 1'b0;
         crit_d_r <= '0;
      end else begin
         if (accept) word_r <= req_addr[3:2];
         crit_v_r <= beat && (cnt == word_r);
         if (beat && (cnt == word_r)) crit_d_r <= mem_r_data;
      end
   end

   assign crit_valid = crit_v_r;
   assign crit_data  = crit_d_r;
`else
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl: latency, wait states, burst-length errors, reset abort, held requests.
module tb_line_fill_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [31:0]   req_addr;
   logic          req_ready;
   logic          mem_ar_valid;
   logic          mem_ar_ready;
   logic [31:0]   mem_ar_addr;
   logic          mem_r_valid;
   logic [31:0]   mem_r_data;
   logic          mem_r_last;
   logic          mem_r_ready;
   logic          line_we;
   logic [31:0]   line_addr;
   logic [127:0]  line_data;
   logic          crit_valid;
   logic [31:0]   crit_data;
   logic          busy;
   logic          err;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            we_cnt  = 0;
   int            crit_cnt = 0;
   logic [31:0]   crit_cap = '0;
   logic [31:0]   exp_ar  = '0;
   logic          ar_bad  = 1'b0;

   line_fill_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
      .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_last(mem_r_last),
      .mem_r_ready(mem_r_ready),
      .line_we(line_we), .line_addr(line_addr), .line_data(line_data),
      .crit_valid(crit_valid), .crit_data(crit_data),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (line_we) we_cnt++;
      if (crit_valid) begin
         crit_cnt++;
         crit_cap = crit_data;
      end
      if (mem_ar_valid && (mem_ar_addr !== exp_ar)) ar_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete fill driven from IDLE; leaves the bench in the first IDLE cycle after line_we.
   task automatic fill(input logic [31:0] addr, input logic [31:0] base, input int ar_wait,
                       input int gap, input int last_at, input bit hold);
      int c0;
      logic [1:0] word;
      word     = addr[3:2];
      exp_ar   = addr & 32'hFFFF_FFF0;
      ar_bad   = 1'b0;
      we_cnt   = 0;
      crit_cnt = 0;
      c0       = cyc;
      req_valid = 1'b1;
      req_addr  = addr;
      step();
      req_valid = hold;
      check("ar_valid", mem_ar_valid, 1'b1);
      check("ar_addr", mem_ar_addr, exp_ar);
      check("err_clr", err, 1'b0);
      for (int i = 0; i < ar_wait; i++) begin
         mem_ar_ready = 1'b0;
         step();
      end
      mem_ar_ready = 1'b1;
      step();
      mem_ar_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            mem_r_valid = 1'b0;
            mem_r_data  = 32'hDEAD_BEEF;
            step();
         end
         mem_r_valid = 1'b1;
         mem_r_data  = base + 32'(k);
         mem_r_last  = (k == last_at);
         step();
         mem_r_valid = 1'b0;
         mem_r_last  = 1'b0;
      end
      check("we", line_we, 1'b1);
      check("latency", cyc - c0, 6 + ar_wait + 4 * gap);
      check("line_addr", line_addr, exp_ar);
      check("line_data", line_data, {base + 32'd3, base + 32'd2, base + 32'd1, base});
      check("err", err, last_at != 3);
      check("ar_stable", ar_bad, 1'b0);
      step();
      check("we_off", line_we, 1'b0);
      check("ready_after", req_ready, 1'b1);
      check("we_cnt", we_cnt, 1);
      check("err_hold", err, last_at != 3);
`ifdef LINE_FILL_CRIT_WORD_EN
      check("crit_cnt", crit_cnt, 1);
      check("crit_data", crit_cap, base + 32'(word));
`else
      check("crit_cnt", crit_cnt, 0);
      check("crit_data", crit_data, 32'h0);
`endif
   endtask

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_addr     = '0;
      mem_ar_ready = 1'b0;
      mem_r_valid  = 1'b0;
      mem_r_data   = '0;
      mem_r_last   = 1'b0;
      repeat (2) step();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ar_valid", mem_ar_valid, 1'b0);
      check("rst_r_ready", mem_r_ready, 1'b0);
      check("rst_line_we", line_we, 1'b0);
      check("rst_crit_valid", crit_valid, 1'b0);
      check("rst_outputs", {mem_ar_addr, line_addr, crit_data, 31'd0, err}, 128'd0);
      check("rst_line_data", line_data, 128'd0);
      rst = 1'b0;
      step();

      // Zero-wait fill
      fill(32'h0000_1234, 32'h0000_00A0, 0, 0, 3, 1'b0);
      // Address wait states and gapped beats
      fill(32'h0000_5678, 32'h0000_00B0, 5, 1, 3, 1'b0);
      // Early last on beat 1
      fill(32'h0000_0040, 32'h0000_00C0, 0, 0, 1, 1'b0);
      // Missing last on beat 3; also clears the previous err on accept
      fill(32'h0000_0038, 32'h0000_00D0, 1, 0, 4, 1'b0);
      // Critical word in slot 2
      fill(32'h0000_0038, 32'h0000_00E0, 0, 0, 3, 1'b0);

      // Reset after beat 2 of a fill
      we_cnt    = 0;
      exp_ar    = 32'h0000_0080;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0084;
      step();
      req_valid    = 1'b0;
      mem_ar_ready = 1'b1;
      step();
      mem_ar_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mem_r_valid = 1'b1;
         mem_r_data  = 32'h0000_0F00 + 32'(k);
         step();
      end
      mem_r_valid = 1'b0;
      check("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      check("abort_ready", req_ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_line", line_data, 128'd0);
      rst = 1'b0;
      repeat (3) step();
      check("abort_we_cnt", we_cnt, 0);
      fill(32'h0000_0038, 32'h0000_0A10, 0, 0, 3, 1'b0);

      // Request held high across a fill, then the next fill accepted right after line_we
      fill(32'h0000_0200, 32'h0000_0100, 2, 0, 3, 1'b1);
      fill(32'h0000_0304, 32'h0000_0200, 0, 0, 3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
